// File: rtl/bool_sweep_checker.sv
// Exhaustive sweep engine: drives every input vector of an N_IN-input boolean DUT in order,
// compares the sampled response with a programmable truth table and records mismatches.
module bool_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 0,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic             cfg_data,
  input  logic             start,
  output logic [N_IN-1:0]  stim_o,
  output logic             stim_valid,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail,
  output logic             first_fail_vld
);

  localparam int DEPTH = 2 ** N_IN;
  localparam int SW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [SW-1:0]    S_ZERO   = {SW{1'b0}};
  localparam logic [SW-1:0]    S_ONE    = SW'(32'd1);
  localparam logic [SW-1:0]    S_LAST   = SW'(SETTLE);
  localparam logic [N_IN-1:0]  V_ZERO   = {N_IN{1'b0}};
  localparam logic [N_IN-1:0]  V_ONE    = N_IN'(32'd1);
  localparam logic [N_IN-1:0]  V_LAST   = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] E_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] E_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] E_MAX    = {CNT_W{1'b1}};
  localparam logic [DEPTH-1:0] TT_CLEAR = {DEPTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [DEPTH-1:0] tt_r;
  logic [N_IN-1:0]  vec_r;
  logic [SW-1:0]    s_r;
  logic             sample_s;
  logic             mismatch_s;

  // Sample-cycle decode and comparison against the stored expectation.
  always_comb begin
    sample_s   = 1'b0;
    mismatch_s = 1'b0;
    if (state_r == RUN && s_r == S_LAST) begin
      sample_s   = 1'b1;
      mismatch_s = (dut_y != tt_r[vec_r]);
    end else begin
      sample_s   = 1'b0;
      mismatch_s = 1'b0;
    end
  end

  assign stim_o = vec_r;
  assign pass   = done && (err_count == E_ZERO);

  // Sweep FSM, truth-table storage and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      tt_r           <= TT_CLEAR;
      vec_r          <= V_ZERO;
      s_r            <= S_ZERO;
      stim_valid     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= E_ZERO;
      first_fail     <= V_ZERO;
      first_fail_vld <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // A write in the start cycle lands before the first sample, so the sweep sees it.
          if (cfg_we) begin
            tt_r[cfg_addr] <= cfg_data;
          end
          if (start) begin
            state_r        <= RUN;
            vec_r          <= V_ZERO;
            s_r            <= S_ZERO;
            stim_valid     <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_count      <= E_ZERO;
            first_fail     <= V_ZERO;
            first_fail_vld <= 1'b0;
          end
        end
        RUN: begin
          if (!sample_s) begin
            s_r <= s_r + S_ONE;
          end else begin
            if (mismatch_s) begin
              if (err_count != E_MAX) begin
                err_count <= err_count + E_ONE;
              end
              if (!first_fail_vld) begin
                first_fail     <= vec_r;
                first_fail_vld <= 1'b1;
              end
            end
            if (vec_r == V_LAST) begin
              state_r    <= DONE;
              stim_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              vec_r <= vec_r + V_ONE;
              s_r   <= S_ZERO;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          stim_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Directed bench for bool_sweep_checker: three instances (SETTLE=0, CNT_W=3, SETTLE=2) driving
// the reference function y=(a&b)|(c&~d), checked through a vector/result scoreboard.
module tb_bool_sweep_checker;

  typedef struct {
    int err;
    int ffv;
    int ff;
    int pass;
    int cycles;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cfg_we, cfg_data, force0;
  logic [3:0] cfg_addr;
  logic       start_a, start_b, start_c;

  logic [3:0] stim_a, stim_b, stim_c;
  logic       sv_a, sv_b, sv_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c;
  logic [4:0] err_a, err_c;
  logic [2:0] err_b;
  logic [3:0] ff_a, ff_b, ff_c;
  logic       ffv_a, ffv_b, ffv_c;
  logic       y_a, y_b, y_c, y1_c;

  function automatic logic f(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & ~v[0]);
  endfunction

  assign y_a = force0 ? 1'b0 : f(stim_a);
  assign y_b = force0 ? 1'b0 : f(stim_b);

  // Two-stage pipelined copy of the reference function for the SETTLE=2 instance.
  always_ff @(posedge clk) begin
    y1_c <= f(stim_c);
    y_c  <= y1_c;
  end

  bool_sweep_checker #(.N_IN(4), .SETTLE(0)) u_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start_a), .stim_o(stim_a), .stim_valid(sv_a), .dut_y(y_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a),
    .first_fail_vld(ffv_a));

  bool_sweep_checker #(.N_IN(4), .SETTLE(0), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start_b), .stim_o(stim_b), .stim_valid(sv_b), .dut_y(y_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b),
    .first_fail_vld(ffv_b));

  bool_sweep_checker #(.N_IN(4), .SETTLE(2)) u_c (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start_c), .stim_o(stim_c), .stim_valid(sv_c), .dut_y(y_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail(ff_c),
    .first_fail_vld(ffv_c));

  int sel;
  int o_stim, o_sv, o_busy, o_done, o_pass, o_err, o_ff, o_ffv;

  always_comb begin
    case (sel)
      1: begin
        o_stim = 32'(stim_b); o_sv = 32'(sv_b); o_busy = 32'(busy_b); o_done = 32'(done_b);
        o_pass = 32'(pass_b); o_err = 32'(err_b); o_ff = 32'(ff_b); o_ffv = 32'(ffv_b);
      end
      2: begin
        o_stim = 32'(stim_c); o_sv = 32'(sv_c); o_busy = 32'(busy_c); o_done = 32'(done_c);
        o_pass = 32'(pass_c); o_err = 32'(err_c); o_ff = 32'(ff_c); o_ffv = 32'(ffv_c);
      end
      default: begin
        o_stim = 32'(stim_a); o_sv = 32'(sv_a); o_busy = 32'(busy_a); o_done = 32'(done_a);
        o_pass = 32'(pass_a); o_err = 32'(err_a); o_ff = 32'(ff_a); o_ffv = 32'(ffv_a);
      end
    endcase
  end

  int          checks   = 0;
  int          failures = 0;
  int          exp_vec_q[$];
  res_t        exp_res_q[$];
  logic [15:0] tt_cur;
  logic [15:0] tt_ref;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic res_t model_res(input logic [15:0] tbl, input logic [15:0] yv,
                                     input int cmax, input int settle);
    res_t r;
    r.err = 0; r.ffv = 0; r.ff = 0;
    for (int k = 0; k < 16; k++) begin
      if (tbl[k] != yv[k]) begin
        if (r.ffv == 0) begin
          r.ffv = 1;
          r.ff  = k;
        end
        if (r.err < cmax) r.err++;
      end
    end
    r.pass   = (r.err == 0) ? 1 : 0;
    r.cycles = 16 * (settle + 1);
    return r;
  endfunction

  task automatic push_vecs(input int settle, input int last);
    for (int k = 0; k <= last; k++)
      for (int h = 0; h <= settle; h++) exp_vec_q.push_back(k);
  endtask

  task automatic set_start(input logic v);
    case (sel)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  task automatic load_table(input logic [15:0] t);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = t[k];
    end
    @(negedge clk);
    cfg_we = 1'b0;
    tt_cur = t;
  endtask

  // Runs one sweep on instance s; optional hooks fire when a given vector first appears.
  task automatic sweep(input int s, input int start_at, input int cfg_at, input int rst_at,
                       input int wr_addr, input int wr_data);
    int   run;
    bit   fin;
    bit   was_rst;
    res_t r;
    sel = s;
    run = 0; fin = 1'b0; was_rst = 1'b0;
    @(negedge clk);
    set_start(1'b1);
    if (wr_addr >= 0) begin
      cfg_we = 1'b1; cfg_addr = 4'(wr_addr); cfg_data = 1'(wr_data);
      tt_cur[wr_addr] = 1'(wr_data);
    end
    @(negedge clk);
    set_start(1'b0);
    cfg_we = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (o_done == 1) begin
        fin = 1'b1;
      end else if (o_sv == 1) begin
        if (run == 0) begin
          check("restart_err_clear", o_err, 0);
          check("restart_ffv_clear", o_ffv, 0);
        end
        run++;
        if (exp_vec_q.size() == 0) check("stim_extra", o_stim, -1);
        else check("stim_o", o_stim, exp_vec_q.pop_front());
        check("busy_run", o_busy, 1);
        if (o_stim == start_at) begin set_start(1'b1); start_at = -1; end
        if (o_stim == cfg_at) begin
          cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = ~tt_cur[12]; cfg_at = -1;
        end
        if (o_stim == rst_at) begin rst = 1'b1; rst_at = -1; end
        @(negedge clk);
        set_start(1'b0);
        cfg_we = 1'b0;
        if (rst == 1'b1) begin
          rst = 1'b0;
          was_rst = 1'b1;
          fin = 1'b1;
          check("rst_busy", o_busy, 0);
          check("rst_done", o_done, 0);
          check("rst_stim_valid", o_sv, 0);
          check("rst_err", o_err, 0);
          check("rst_ffv", o_ffv, 0);
        end
      end else begin
        check("sweep_stalled", o_sv, 1);
        @(negedge clk);
      end
    end
    check("sweep_timeout", 32'(fin), 1);
    check("vec_q_left", exp_vec_q.size(), 0);
    if (!was_rst && fin) begin
      r = exp_res_q.pop_front();
      check("err_count", o_err, r.err);
      check("first_fail_vld", o_ffv, r.ffv);
      check("first_fail", o_ff, r.ff);
      check("pass", o_pass, r.pass);
      check("run_cycles", run, r.cycles);
      check("done_busy", o_busy, 0);
      check("done_stim_valid", o_sv, 0);
      check("done_stim_hold", o_stim, 15);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 1'b0; force0 = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; sel = 0;
    tt_cur = 16'h0000;
    for (int k = 0; k < 16; k++) tt_ref[k] = f(4'(k));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_pass", o_pass, 0);
    check("reset_stim_valid", o_sv, 0);
    check("reset_stim", o_stim, 0);
    check("reset_err", o_err, 0);
    check("reset_ffv", o_ffv, 0);

    // Correct table, full sweep.
    load_table(tt_ref);
    push_vecs(0, 15);
    exp_res_q.push_back(model_res(tt_ref, tt_ref, 31, 0));
    sweep(0, -1, -1, -1, -1, 0);

    // Entry 5 flipped, written in the same cycle as start.
    push_vecs(0, 15);
    tt_ref[5] = ~tt_ref[5];
    exp_res_q.push_back(model_res(tt_ref, {tt_ref[15:6], ~tt_ref[5], tt_ref[4:0]}, 31, 0));
    sweep(0, -1, -1, -1, 5, 32'(tt_ref[5]));
    tt_ref[5] = ~tt_ref[5];

    // Restart from DONE with entry 5 restored; start and cfg_we mid-sweep must be ignored.
    push_vecs(0, 15);
    exp_res_q.push_back(model_res(tt_ref, tt_ref, 31, 0));
    sweep(0, 7, 9, -1, 5, 32'(tt_ref[5]));

    // DUT stuck at 0 against an all-ones table, wide and saturating counters.
    force0 = 1'b1;
    load_table(16'hFFFF);
    push_vecs(0, 15);
    exp_res_q.push_back(model_res(16'hFFFF, 16'h0000, 31, 0));
    sweep(0, -1, -1, -1, -1, 0);
    push_vecs(0, 15);
    exp_res_q.push_back(model_res(16'hFFFF, 16'h0000, 7, 0));
    sweep(1, -1, -1, -1, -1, 0);
    force0 = 1'b0;

    // Two-stage pipelined DUT with SETTLE=2.
    load_table(tt_ref);
    push_vecs(2, 15);
    exp_res_q.push_back(model_res(tt_ref, tt_ref, 31, 2));
    sweep(2, -1, -1, -1, -1, 0);

    // Reset mid-sweep at vector 10, then sweep against the cleared table.
    push_vecs(0, 10);
    sweep(0, -1, -1, 10, -1, 0);
    tt_cur = 16'h0000;
    push_vecs(0, 15);
    exp_res_q.push_back(model_res(16'h0000, tt_ref, 31, 0));
    sweep(0, -1, -1, -1, -1, 0);

    check("res_q_left", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
